// File: rtl/lms_sched_pkg.sv
// rtl/lms_sched_pkg.sv - shared types, defaults and helpers for the LMS FIFO read scheduler
// Contents:
//   sched_state_t : scheduler FSM states
//   DEF_DATA_W    : default sample width
//   DEF_LVL_W     : default FIFO water-level width
//   cnt_width()   : width of the per-frame issue/accept counters
package lms_sched_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LVL_W  = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_BURST = 3'd3,
        ST_DRAIN = 3'd4
    } sched_state_t;

    // Counters must hold the value FRAME_LEN itself (terminal count).
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/lms_pair_skid.sv
// rtl/lms_pair_skid.sv - 2-entry (x, d) pair buffer with in-flight read accounting
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   issue           : a paired FIFO read is issued this cycle (data returns next cycle)
//   in_x, in_d      : FIFO read data, valid the cycle after issue
//   out_x, out_d    : buffer head
//   out_valid       : head holds a pair
//   out_ready       : consumer accepts the head
//   can_issue       : a new read issued now is guaranteed a free slot on return
module lms_pair_skid #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_d,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              can_issue
);

    logic              in_flight;
    logic [1:0]        count;
    logic [DATA_W-1:0] e0_x, e0_d, e1_x, e1_d;
    logic              push, pop;
    logic [2:0]        occ_after_pop;

    assign push      = in_flight;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);
    assign out_x     = e0_x;
    assign out_d     = e0_d;

    // Credit counts this cycle's pop so a full-rate stream keeps issuing every
    // cycle; pop implies count >= 1, so the subtraction never underflows.
    assign occ_after_pop = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
    assign can_issue     = (occ_after_pop < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= 1'b0;
            count     <= 2'd0;
            e0_x      <= '0;
            e0_d      <= '0;
            e1_x      <= '0;
            e1_d      <= '0;
        end else begin
            in_flight <= issue;
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd1) begin
                        e0_x <= in_x;
                        e0_d <= in_d;
                    end else begin
                        e0_x <= e1_x;
                        e0_d <= e1_d;
                        e1_x <= in_x;
                        e1_d <= in_d;
                    end
                end
                2'b01: begin
                    e0_x  <= e1_x;
                    e0_d  <= e1_d;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        e0_x <= in_x;
                        e0_d <= in_d;
                    end else begin
                        e1_x <= in_x;
                        e1_d <= in_d;
                    end
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lms_fifo_rd_sched.sv
// rtl/lms_fifo_rd_sched.sv - read scheduler pairing the x and d LMS sample FIFOs into framed streams
// Optional feature macro: LMS_SCHED_STAT_EN (adds frm_cnt / flush_smp_cnt statistics outputs)
// Ports:
//   rd_clk, rd_rst          : read clock, asynchronous active-high reset
//   en                      : scheduler enable
//   x_rd_* / d_rd_*         : FIFO read enable, data (1-cycle latency), empty flag, water level
//   smp_x, smp_d, smp_valid : aligned sample pair stream, smp_ready from the LMS core
//   smp_first, smp_last     : frame markers, qualified by smp_valid
//   frm_done                : 1-cycle pulse after the last pair of a frame is accepted
//   skew_flag               : sticky, set by any skew flush
//   frm_cnt, flush_smp_cnt  : statistics (LMS_SCHED_STAT_EN only)
module lms_fifo_rd_sched
    import lms_sched_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LVL_W     = DEF_LVL_W,
    parameter int FRAME_LEN = 64,
    parameter int SKEW_MAX  = 8
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              en,
    output logic              x_rd_en,
    input  logic [DATA_W-1:0] x_rd_data,
    input  logic              x_rd_empty,
    input  logic [LVL_W-1:0]  x_rd_water_level,
    output logic              d_rd_en,
    input  logic [DATA_W-1:0] d_rd_data,
    input  logic              d_rd_empty,
    input  logic [LVL_W-1:0]  d_rd_water_level,
    output logic [DATA_W-1:0] smp_x,
    output logic [DATA_W-1:0] smp_d,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              smp_first,
    output logic              smp_last,
    output logic              frm_done,
    output logic              skew_flag
`ifdef LMS_SCHED_STAT_EN
    ,
    output logic [15:0]       frm_cnt,
    output logic [15:0]       flush_smp_cnt
`endif
);

    localparam int              CNT_W     = cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
    localparam logic [LVL_W-1:0] FRAME_LVL = LVL_W'(FRAME_LEN);
    localparam logic [LVL_W-1:0] SKEW_LVL  = LVL_W'(SKEW_MAX);

    sched_state_t       state, state_nxt;
    logic [LVL_W-1:0]   flush_cnt;
    logic               flush_x;        // 1: x is the deeper channel being flushed
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   accepted;

    logic signed [LVL_W:0] diff, neg_diff;
    logic [LVL_W-1:0]   abs_diff;
    logic               skew_hit, lvl_ok;
    logic               can_issue, burst_rd, flush_rd, pair_hs, frame_end;

    // Level difference, one bit wider than the levels so it cannot overflow.
    assign diff     = $signed({1'b0, x_rd_water_level}) - $signed({1'b0, d_rd_water_level});
    assign neg_diff = -diff;
    assign abs_diff = diff[LVL_W] ? neg_diff[LVL_W-1:0] : diff[LVL_W-1:0];
    assign skew_hit = (abs_diff > SKEW_LVL);
    assign lvl_ok   = (x_rd_water_level >= FRAME_LVL) && (d_rd_water_level >= FRAME_LVL);

    assign pair_hs   = smp_valid & smp_ready;
    assign frame_end = (state == ST_DRAIN) && (accepted == FRAME_CNT);

    lms_pair_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .issue     (burst_rd),
        .in_x      (x_rd_data),
        .in_d      (d_rd_data),
        .out_x     (smp_x),
        .out_d     (smp_d),
        .out_valid (smp_valid),
        .out_ready (smp_ready),
        .can_issue (can_issue)
    );

    assign smp_first = smp_valid && (accepted == '0);
    assign smp_last  = smp_valid && (accepted == LAST_IDX);

    // State register
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (!en)           state_nxt = ST_IDLE;
                else if (skew_hit) state_nxt = ST_FLUSH;
                else if (lvl_ok)   state_nxt = ST_BURST;
            end
            ST_FLUSH: begin
                if (flush_cnt == '0) state_nxt = ST_ARM;
            end
            ST_BURST: begin
                if (issued == FRAME_CNT) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (frame_end) state_nxt = en ? ST_ARM : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: read enables
    always_comb begin
        burst_rd = 1'b0;
        flush_rd = 1'b0;
        case (state)
            ST_BURST: burst_rd = !x_rd_empty && !d_rd_empty && (issued != FRAME_CNT) && can_issue;
            ST_FLUSH: flush_rd = (flush_cnt != '0) && (flush_x ? !x_rd_empty : !d_rd_empty);
            default: ;
        endcase
        x_rd_en = burst_rd | (flush_rd & flush_x);
        d_rd_en = burst_rd | (flush_rd & ~flush_x);
    end

    // Datapath counters and flags
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            flush_cnt <= '0;
            flush_x   <= 1'b0;
            skew_flag <= 1'b0;
            issued    <= '0;
            accepted  <= '0;
            frm_done  <= 1'b0;
        end else begin
            frm_done <= pair_hs && (accepted == LAST_IDX);

            if (state == ST_ARM && en && skew_hit) begin
                flush_cnt <= abs_diff;
                flush_x   <= ~diff[LVL_W];
                skew_flag <= 1'b1;
            end else if (flush_rd) begin
                flush_cnt <= flush_cnt - 1'b1;
            end

            if (frame_end) begin
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (burst_rd) issued   <= issued + 1'b1;
                if (pair_hs)  accepted <= accepted + 1'b1;
            end
        end
    end

`ifdef LMS_SCHED_STAT_EN
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            frm_cnt       <= 16'd0;
            flush_smp_cnt <= 16'd0;
        end else begin
            if (pair_hs && (accepted == LAST_IDX)) frm_cnt <= frm_cnt + 16'd1;
            if (flush_rd && (flush_smp_cnt != 16'hFFFF)) flush_smp_cnt <= flush_smp_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lms_fifo_rd_sched.sv
// tb/tb_lms_fifo_rd_sched.sv - scoreboard bench for lms_fifo_rd_sched
module tb_lms_fifo_rd_sched;

    localparam int DATA_W = 16;
    localparam int LVL_W  = 12;
    localparam int FLEN   = 64;

    logic              clk = 1'b0;
    logic              rd_rst = 1'b1;
    logic              en = 1'b0;
    logic              x_rd_en, d_rd_en;
    logic [DATA_W-1:0] x_rd_data = '0, d_rd_data = '0;
    logic              x_rd_empty = 1'b1, d_rd_empty = 1'b1;
    logic [LVL_W-1:0]  x_lvl = '0, d_lvl = '0;
    logic [DATA_W-1:0] smp_x, smp_d;
    logic              smp_valid, smp_ready, smp_first, smp_last, frm_done, skew_flag;

    always #5 clk = ~clk;

    lms_fifo_rd_sched #(
        .DATA_W (DATA_W), .LVL_W (LVL_W), .FRAME_LEN (FLEN), .SKEW_MAX (8)
    ) dut (
        .rd_clk (clk), .rd_rst (rd_rst), .en (en),
        .x_rd_en (x_rd_en), .x_rd_data (x_rd_data), .x_rd_empty (x_rd_empty), .x_rd_water_level (x_lvl),
        .d_rd_en (d_rd_en), .d_rd_data (d_rd_data), .d_rd_empty (d_rd_empty), .d_rd_water_level (d_lvl),
        .smp_x (smp_x), .smp_d (smp_d), .smp_valid (smp_valid), .smp_ready (smp_ready),
        .smp_first (smp_first), .smp_last (smp_last), .frm_done (frm_done), .skew_flag (skew_flag)
    );

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] d;
        logic        first;
        logic        last;
    } pair_t;

    pair_t       exp_q[$];
    logic [15:0] x_q[$], d_q[$];

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO models: pop on rd_en, data returns next cycle, flags follow the queue.
    int   x_reads = 0, d_reads = 0, both_reads = 0, gap_reads = 0, proto_err = 0;
    logic d_gate = 1'b0;

    always @(posedge clk) begin
        if (x_rd_en) begin
            x_reads++;
            if (x_q.size() == 0) proto_err++;
            else x_rd_data <= x_q.pop_front();
        end
        if (d_rd_en) begin
            d_reads++;
            if (d_q.size() == 0) proto_err++;
            else d_rd_data <= d_q.pop_front();
        end
        if (x_rd_en && d_rd_en) both_reads++;
        if ((x_rd_en || d_rd_en) && d_rd_empty) gap_reads++;
        x_lvl      <= LVL_W'(x_q.size());
        d_lvl      <= LVL_W'(d_q.size());
        x_rd_empty <= (x_q.size() == 0);
        d_rd_empty <= (d_q.size() == 0) || d_gate;
    end

    // Consumer ready: 1 = held high, 2 = toggling every cycle.
    int ready_mode = 1;
    initial begin
        smp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) smp_ready = ~smp_ready;
            else                 smp_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks frm_done timing and stall stability.
    int          n_acc = 0, n_done = 0, cyc = 0, t_first = 0, t_last = 0;
    logic        done_exp = 1'b0, prev_stall = 1'b0;
    logic [34:0] held = '0;
    pair_t       mon_e;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_rst) begin
                done_exp   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (frm_done) n_done++;
                if (frm_done || done_exp) check("frm_done_timing", 64'(frm_done), 64'(done_exp));
                done_exp = 1'b0;
                if (prev_stall)
                    check("stall_hold", 64'({smp_valid, smp_x, smp_d, smp_first, smp_last}), 64'(held));
                if (smp_valid && smp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pair_unexpected: got x=0x%0h d=0x%0h, expected no pair", smp_x, smp_d);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("pair", 64'({smp_x, smp_d, smp_first, smp_last}),
                              64'({mon_e.x, mon_e.d, mon_e.first, mon_e.last}));
                        done_exp = mon_e.last;
                        if (mon_e.first) t_first = cyc;
                        if (mon_e.last)  t_last  = cyc;
                    end
                    n_acc++;
                end
                prev_stall = smp_valid && !smp_ready;
                held       = {smp_valid, smp_x, smp_d, smp_first, smp_last};
            end
        end
    end

    task automatic preload(input int nx, input int nd, input logic [15:0] xb, input logic [15:0] db);
        for (int i = 0; i < nx; i++) x_q.push_back(xb + 16'(i));
        for (int i = 0; i < nd; i++) d_q.push_back(db + 16'(i));
        repeat (3) @(negedge clk);
    endtask

    task automatic push_exp(input logic [15:0] xb, input logic [15:0] db);
        pair_t p;
        for (int i = 0; i < FLEN; i++) begin
            p.x = xb + 16'(i);
            p.d = db + 16'(i);
            p.first = (i == 0);
            p.last  = (i == FLEN - 1);
            exp_q.push_back(p);
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int c = 0;
        while (n_done < target && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({name, "_frame_done"}, 64'(n_done >= target), 64'd1);
    endtask

    task automatic wait_acc(input int target, input string name);
        int c = 0;
        while (n_acc < target && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({name, "_reach_pair"}, 64'(n_acc >= target), 64'd1);
    endtask

    int xr0, dr0, br0, gr0, nd0, na0;

    task automatic snap();
        xr0 = x_reads; dr0 = d_reads; br0 = both_reads; gr0 = gap_reads; nd0 = n_done; na0 = n_acc;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({x_rd_en, d_rd_en, smp_valid, smp_first, smp_last, frm_done, skew_flag,
                                     smp_x, smp_d}), 64'd0);
        rd_rst = 1'b0;

        // 1: plain frame at full rate
        preload(64, 64, 16'h1000, 16'h2000);
        push_exp(16'h1000, 16'h2000);
        snap();
        en = 1'b1;
        wait_done(nd0 + 1, "s1");
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("s1_all_pairs", 64'(exp_q.size()), 64'd0);
        check("s1_x_reads", 64'(x_reads - xr0), 64'd64);
        check("s1_d_reads", 64'(d_reads - dr0), 64'd64);
        check("s1_throughput", 64'(t_last - t_first), 64'd63);
        check("s1_skew_flag", 64'(skew_flag), 64'd0);

        // 2: consumer toggling ready
        preload(64, 64, 16'h3000, 16'h4000);
        push_exp(16'h3000, 16'h4000);
        snap();
        ready_mode = 2;
        en = 1'b1;
        wait_done(nd0 + 1, "s2");
        en = 1'b0;
        ready_mode = 1;
        repeat (4) @(negedge clk);
        check("s2_all_pairs", 64'(exp_q.size()), 64'd0);
        check("s2_x_reads", 64'(x_reads - xr0), 64'd64);
        check("s2_d_reads", 64'(d_reads - dr0), 64'd64);

        // 3: x 80 deep, d 70 deep -> 10 x samples flushed, then x(n+10) pairs with d(n)
        preload(80, 70, 16'h5000, 16'h6000);
        push_exp(16'h500A, 16'h6000);
        snap();
        en = 1'b1;
        wait_done(nd0 + 1, "s3");
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("s3_all_pairs", 64'(exp_q.size()), 64'd0);
        check("s3_skew_flag", 64'(skew_flag), 64'd1);
        check("s3_x_reads", 64'(x_reads - xr0), 64'd74);
        check("s3_d_reads", 64'(d_reads - dr0), 64'd64);
        check("s3_paired_reads", 64'(both_reads - br0), 64'd64);
        x_q.delete();
        d_q.delete();

        // 4: d FIFO reports empty for 5 cycles mid-burst
        preload(64, 64, 16'h7000, 16'h7800);
        push_exp(16'h7000, 16'h7800);
        snap();
        en = 1'b1;
        wait_acc(na0 + 20, "s4");
        d_gate = 1'b1;
        repeat (5) @(negedge clk);
        d_gate = 1'b0;
        wait_done(nd0 + 1, "s4");
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("s4_all_pairs", 64'(exp_q.size()), 64'd0);
        check("s4_reads_in_gap", 64'(gap_reads - gr0), 64'd0);
        check("s4_x_reads", 64'(x_reads - xr0), 64'd64);

        // 5: en dropped at pair 20 with two frames' worth available
        preload(128, 128, 16'h8000, 16'h9000);
        push_exp(16'h8000, 16'h9000);
        snap();
        en = 1'b1;
        wait_acc(na0 + 20, "s5");
        en = 1'b0;
        wait_done(nd0 + 1, "s5");
        repeat (20) @(negedge clk);
        check("s5_all_pairs", 64'(exp_q.size()), 64'd0);
        check("s5_x_reads", 64'(x_reads - xr0), 64'd64);
        check("s5_d_reads", 64'(d_reads - dr0), 64'd64);
        check("s5_idle_valid", 64'(smp_valid), 64'd0);
        x_q.delete();
        d_q.delete();

        // 6: reset at pair 30, then a fresh frame
        preload(64, 64, 16'hA000, 16'hB000);
        push_exp(16'hA000, 16'hB000);
        snap();
        en = 1'b1;
        wait_acc(na0 + 30, "s6");
        #1;
        rd_rst = 1'b1;
        #1;
        check("s6_async_reset", 64'({x_rd_en, d_rd_en, smp_valid, smp_first, smp_last, frm_done, skew_flag}),
              64'd0);
        exp_q.delete();
        en = 1'b0;
        repeat (2) @(negedge clk);
        rd_rst = 1'b0;
        x_q.delete();
        d_q.delete();
        preload(64, 64, 16'hC000, 16'hD000);
        push_exp(16'hC000, 16'hD000);
        en = 1'b1;
        wait_done(nd0 + 1, "s6");
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("s6_all_pairs", 64'(exp_q.size()), 64'd0);
        check("s6_single_done", 64'(n_done - nd0), 64'd1);
        check("s6_skew_cleared", 64'(skew_flag), 64'd0);

        check("no_empty_reads", 64'(proto_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lms_fifo_rd_sched.md
Name: lms_fifo_rd_sched

Overview:
- Read-side scheduler for the two LMS sample FIFOs: x (reference mic) and d (desired/error mic). Both FIFOs run on the same read clock.
- Waits until both FIFOs hold one full frame, then pops them in lockstep and presents aligned (x, d) pairs to the LMS core over a valid/ready stream.
- Detects inter-channel skew and re-aligns the channels by discarding excess samples from the deeper FIFO.

Parameters:
- DATA_W, 16, sample width; matches the FIFO data width.
- LVL_W, 12, FIFO water-level width (depth width + 1).
- FRAME_LEN, 64, samples per frame; legal range 2..2^(LVL_W-1).
- SKEW_MAX, 8, largest tolerated level difference between x and d before a flush.

Ports:
- rd_clk  in  1  read-side clock shared with both FIFO read ports.
- rd_rst  in  1  asynchronous reset, active-high.
- en  in  1  scheduler enable.
- x_rd_en  out  1  x FIFO read enable.
- x_rd_data  in  DATA_W  x FIFO data; valid 1 cycle after x_rd_en.
- x_rd_empty  in  1  x FIFO empty flag.
- x_rd_water_level  in  LVL_W  x FIFO fill level.
- d_rd_en, d_rd_data, d_rd_empty, d_rd_water_level: same as the x ports, for the d FIFO.
- smp_x  out  DATA_W  reference sample to the LMS core.
- smp_d  out  DATA_W  desired sample to the LMS core.
- smp_valid  out  1  sample pair valid.
- smp_ready  in  1  LMS core accepts the pair.
- smp_first  out  1  first pair of a frame; qualified by smp_valid.
- smp_last  out  1  last pair of a frame; qualified by smp_valid.
- frm_done  out  1  1-cycle pulse after the last pair of a frame is accepted.
- skew_flag  out  1  sticky; set by any flush, cleared only by rd_rst.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, output buffer empty.
- States:
  - IDLE: go to ARM when en=1.
  - ARM:
    - If en=0, go to IDLE.
    - Otherwise compute diff = x_lvl - d_lvl (signed, LVL_W+1 bits).
    - If |diff| > SKEW_MAX: latch flush_cnt = |diff| and the deeper channel, set skew_flag, go to FLUSH.
    - Else if both levels >= FRAME_LEN: go to BURST.
  - FLUSH:
    - Assert rd_en on the deeper channel only, 1 per cycle, while that FIFO is non-empty.
    - Discard the returned data and decrement flush_cnt per read.
    - At 0, return to ARM. Level inputs are ignored during FLUSH.
  - BURST:
    - Assert x_rd_en and d_rd_en together when both are non-empty, issued < FRAME_LEN, and buffered + in_flight < 2.
    - At issued == FRAME_LEN, go to DRAIN.
  - DRAIN:
    - When the accepted count reaches FRAME_LEN, pulse frm_done in the cycle after the final handshake.
    - Then go to ARM if en=1, else IDLE.
- Read latency:
  - FIFO data is captured 1 cycle after rd_en into a 2-entry pair buffer.
  - smp_* come from the buffer head.
  - Read-issue to smp_valid is 2 cycles minimum.
- Stream rules:
  - Once smp_valid is asserted, it and smp_* hold stable until smp_ready.
  - A pop and a push in the same cycle are allowed.
  - With smp_ready held high and both FIFOs non-empty, throughput is 1 pair per cycle.
- smp_first is high on accepted index 0; smp_last on index FRAME_LEN-1.
- x_rd_en and d_rd_en are never asserted together except in BURST. They are never asserted into an empty FIFO.
- en deasserted mid-frame: the current frame completes (BURST/DRAIN), then the block goes to IDLE. en has no effect in FLUSH.
- rd_rst mid-frame: immediate return to reset state. The partial frame is lost and no frm_done is produced.
- Counters are $clog2(FRAME_LEN+1) bits wide and saturate-free, because the FSM bounds them.

Optional Feature:
- LMS_SCHED_STAT_EN defined:
  - Adds output frm_cnt[15:0], frames completed, wraps at 0xFFFF.
  - Adds output flush_smp_cnt[15:0], total samples discarded, saturates at 0xFFFF.
  - Both are cleared by rd_rst.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

Decomposition:
- Package lms_sched_pkg holds:
  - the state enum (IDLE, ARM, FLUSH, BURST, DRAIN);
  - the default DATA_W and LVL_W;
  - a function that computes the counter width from FRAME_LEN.
- One sub-module, lms_pair_skid: the 2-entry valid/ready pair buffer with in-flight accounting. The FSM stays in the top level.

Test Plan:
- FRAME_LEN=64, both FIFOs preloaded with 64 samples, smp_ready=1 -> 64 pairs in order; smp_first on pair 0, smp_last on pair 63; frm_done 1 cycle after pair 63; skew_flag=0.
- Same preload, smp_ready toggling 1/0 each cycle -> no pair lost or duplicated; smp_* stable while stalled; x and d FIFOs each drained by exactly 64 reads.
- x level 80, d level 70, SKEW_MAX=8 -> FLUSH discards exactly 10 x samples; skew_flag=1; then a 64-pair frame whose d_n pairs with x_(n+10).
- d FIFO empty for 5 cycles mid-BURST -> neither rd_en asserts during the gap; the frame completes with correct alignment.
- en dropped at pair 20 -> frame completes through pair 63, frm_done pulses, state IDLE, no further reads.
- rd_rst asserted at pair 30 -> all outputs 0 in the same cycle (asynchronous); no frm_done; a restarted frame begins again at smp_first.
